// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch-stage program counter with one-deep redirect buffer and misalignment fault
// Optional feature macro PC_RVC_EN: 2-byte alignment and the is_compressed input.
module pc_fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_imm,
  input  logic            jalr_valid,
  input  logic [XLEN-1:0] jalr_rs1,
  input  logic [XLEN-1:0] jalr_imm,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
`ifdef PC_RVC_EN
  input  logic            is_compressed,
`endif
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq,
  output logic            misalign_fault,
  output logic [XLEN-1:0] fault_addr
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("pc_fetch_unit: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q, fault_addr_q, pend_addr_q;
  logic            valid_q, fault_q, pend_valid_q, pend_trap_q;
  logic [XLEN-1:0] seq_inc, tgt, jalr_sum;
  logic            redirect, tgt_misaligned, accept;

`ifdef PC_RVC_EN
  if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_instr_bytes
    $error("pc_fetch_unit: INSTR_BYTES must be 2 or 4");
  end
  assign seq_inc = is_compressed ? XLEN'(2) : XLEN'(4);
`else
  if (INSTR_BYTES != 4) begin : g_bad_instr_bytes
    $error("pc_fetch_unit: INSTR_BYTES must be 4 without compressed support");
  end
  assign seq_inc = XLEN'(INSTR_BYTES);
`endif

  always_comb begin
    jalr_sum = jalr_rs1 + jalr_imm;
    redirect = trap_valid | jalr_valid | branch_taken;
    tgt      = pc_q + branch_imm;
    if (trap_valid)      tgt = trap_vector;
    else if (jalr_valid) tgt = jalr_sum & ~XLEN'(1);
    // trap vectors are trusted; only jalr/branch targets can fault
`ifdef PC_RVC_EN
    tgt_misaligned = !trap_valid && redirect && tgt[0];
`else
    tgt_misaligned = !trap_valid && redirect && (tgt[1:0] != 2'b00);
`endif
    accept = valid_q && imem_req_ready && !stall;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            if (pend_valid_q) begin
              pc_q <= pend_addr_q;
            end else if (tgt_misaligned) begin
              state_q      <= FAULT;
              valid_q      <= 1'b0;
              fault_q      <= 1'b1;
              fault_addr_q <= tgt;
            end else if (redirect) begin
              pc_q <= tgt;
            end else begin
              pc_q <= pc_q + seq_inc;
            end
          end else if (redirect && (trap_valid || !pend_trap_q)) begin
            // held cycle: the slot is validated here so it can be loaded blindly later
            if (tgt_misaligned) begin
              state_q      <= FAULT;
              valid_q      <= 1'b0;
              fault_q      <= 1'b1;
              fault_addr_q <= tgt;
              pend_valid_q <= 1'b0;
              pend_trap_q  <= 1'b0;
            end else begin
              pend_valid_q <= 1'b1;
              pend_trap_q  <= trap_valid;
              pend_addr_q  <= tgt;
            end
          end
        end
        FAULT: begin
          if (trap_valid) begin
            state_q      <= RUN;
            valid_q      <= 1'b1;
            fault_q      <= 1'b0;
            pc_q         <= trap_vector;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = valid_q;
  assign pc_out         = pc_q;
  assign pc_seq         = pc_q + seq_inc;
  assign misalign_fault = fault_q;
  assign fault_addr     = fault_addr_q;

endmodule
